key_move_scheduler: RTL

//  Turns the registered arrow-key state {left,right,down,up} into timed square

---
 rtl/key_move_scheduler_if.sv | 23 ++
 rtl/key_move_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/key_move_scheduler_if.sv
// key_move_scheduler_if: keyboard-side inputs and game-side position outputs
// of the arrow-key move scheduler, bundled so both ends share one definition.
// master = keyboard/game side, slave = the scheduler itself.
interface key_move_scheduler_if #(
    parameter int POS_W = 10
);
    logic [3:0]       keys;        // [0]=up [1]=down [2]=right [3]=left
    logic             pause;       // 1 = freeze scheduling and position
    logic [POS_W-1:0] pos_x;       // square x position
    logic [POS_W-1:0] pos_y;       // square y position
    logic             step_pulse;  // high in the cycle a new position is visible
    logic [3:0]       dir;         // resolved direction of the last step

    modport master (
        output keys, pause,
        input  pos_x, pos_y, step_pulse, dir
    );

    modport slave (
        input  keys, pause,
        output pos_x, pos_y, step_pulse, dir
    );
endinterface

// File: rtl/key_move_scheduler.sv
// key_move_scheduler: converts held arrow keys into timed position steps.
// One step on press, first repeat DELAY_CYC cycles later, then one step every
// REPEAT_CYC cycles while the resolved direction stays the same. Owns the
// player position registers.
// Build option: define MOVE_WRAP_EN to wrap around the play-field edges
// instead of clamping to them. Ports are identical in both builds.
module key_move_scheduler #(
    parameter int POS_W      = 10,
    parameter int X_MAX      = 620,
    parameter int Y_MAX      = 460,
    parameter int X_INIT     = 310,
    parameter int Y_INIT     = 230,
    parameter int STEP       = 4,
    parameter int DELAY_CYC  = 12_500_000,
    parameter int REPEAT_CYC = 2_500_000
) (
    input  logic                clk_50,
    input  logic                reset,
    key_move_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    // Per-axis movement: none, positive (right/down) or negative (left/up).
    typedef enum logic [1:0] {D_ZERO = 2'b00, D_POS = 2'b01, D_NEG = 2'b11} delta_t;

    typedef struct packed {
        delta_t dx;
        delta_t dy;
    } vec_t;

    localparam logic [POS_W-1:0] STEP_P   = POS_W'(STEP);
    localparam logic [POS_W:0]   STEP_W   = (POS_W+1)'(STEP);
    localparam logic [POS_W-1:0] X_MAX_P  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_MAX_P  = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_INIT_P = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_INIT_P = POS_W'(Y_INIT);
    // The counter is loaded with N-1 and the step fires when it reads zero,
    // so consecutive steps are exactly N cycles apart (N=1 steps every cycle).
    localparam logic [31:0] DELAY_LOAD  = 32'(DELAY_CYC - 1);
    localparam logic [31:0] REPEAT_LOAD = 32'(REPEAT_CYC - 1);

    // One axis update; the sum is formed one bit wider so overflow past
    // the edge is detected rather than wrapping silently.
    function automatic logic [POS_W-1:0] move_axis(
        input logic [POS_W-1:0] p,
        input delta_t           d,
        input logic [POS_W-1:0] max_p
    );
        logic [POS_W:0]   sum;
        logic [POS_W-1:0] res;
        sum = {1'b0, p} + STEP_W;
        res = p;
        case (d)
            D_POS: begin
                if (sum > {1'b0, max_p}) begin
`ifdef MOVE_WRAP_EN
                    res = '0;
`else
                    res = max_p;
`endif
                end else begin
                    res = sum[POS_W-1:0];
                end
            end
            D_NEG: begin
                if (p < STEP_P) begin
`ifdef MOVE_WRAP_EN
                    res = max_p;
`else
                    res = '0;
`endif
                end else begin
                    res = p - STEP_P;
                end
            end
            default: res = p;
        endcase
        return res;
    endfunction

    state_t           state, state_d;
    logic [31:0]      cnt, cnt_d;
    vec_t             dv, dv_q;
    logic             active;
    logic             changed;
    logic             do_step;
    logic [3:0]       step_dir;
    logic [POS_W-1:0] pos_x_q, pos_y_q;
    logic [POS_W-1:0] pos_x_n, pos_y_n;
    logic             step_q;
    logic [3:0]       dir_q;

    // Resolve the four key levels into a movement vector; opposing keys cancel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        dv.dx = D_ZERO;
        dv.dy = D_ZERO;
        if (bus.keys[0] && !bus.keys[1]) dv.dy = D_NEG;
        else if (bus.keys[1] && !bus.keys[0]) dv.dy = D_POS;
        if (bus.keys[2] && !bus.keys[3]) dv.dx = D_POS;
        else if (bus.keys[3] && !bus.keys[2]) dv.dx = D_NEG;
    end

    assign active   = (dv.dx != D_ZERO) || (dv.dy != D_ZERO);
    assign changed  = (dv != dv_q);
    assign step_dir = {dv.dx == D_NEG, dv.dx == D_POS, dv.dy == D_POS, dv.dy == D_NEG};
    assign pos_x_n  = move_axis(pos_x_q, dv.dx, X_MAX_P);
    assign pos_y_n  = move_axis(pos_y_q, dv.dy, Y_MAX_P);

    // Scheduler next state: decides whether this cycle steps and reloads the timer.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        do_step = 1'b0;
        if (bus.pause) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active) begin
                        do_step = 1'b1;
                        cnt_d   = DELAY_LOAD;
                        state_d = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!active) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (changed) begin
                        // A new direction restarts the typematic delay.
                        do_step = 1'b1;
                        cnt_d   = DELAY_LOAD;
                        state_d = DELAY;
                    end else if (cnt == '0) begin
                        do_step = 1'b1;
                        cnt_d   = REPEAT_LOAD;
                        state_d = REPEAT;
                    end else begin
                        cnt_d   = cnt - 32'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, timer and position registers; reset dominates every other input.
    always_ff @(posedge clk_50) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dv_q    <= '{dx: D_ZERO, dy: D_ZERO};
            pos_x_q <= X_INIT_P;
            pos_y_q <= Y_INIT_P;
            step_q  <= 1'b0;
            dir_q   <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            step_q <= do_step;
            if (do_step) begin
                dv_q    <= dv;
                pos_x_q <= pos_x_n;
                pos_y_q <= pos_y_n;
                dir_q   <= step_dir;
            end
        end
    end

    assign bus.pos_x      = pos_x_q;
    assign bus.pos_y      = pos_y_q;
    assign bus.step_pulse = step_q;
    assign bus.dir        = dir_q;

endmodule
